// File: rtl/scan_frame_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_frame_pkg
//  Description : Shared types and constants for the scan frame loader:
//                FSM state encoding, default frame width / settle time and
//                the counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package scan_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_APPLY  = 2'd2,
      ST_SETTLE = 2'd3
   } state_e;

   localparam int c_def_width  = 8;
   localparam int c_def_settle = 1;

   // Settle counter holds SETTLE-1, SETTLE in 1..15.
   localparam int c_settle_cnt_w = 4;

   // Width of a counter that must hold the value w itself.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

   localparam int c_def_cnt_w = cnt_width(c_def_width);

endpackage
`default_nettype wire

// File: rtl/scan_frame_loader_piso.sv
`default_nettype none
// ============================================================================
//  Module      : scan_piso
//  Description : Parallel-load, serial-out shifter for captured results.
//                A load presents data_i[0] on the following cycle and then
//                one bit per cycle, LSB first, for WIDTH cycles. No
//                backpressure.
//  Ports       : clk     - clock
//                reset   - asynchronous active-high reset
//                load_i  - load data_i and start a WIDTH-bit burst
//                data_i  - parallel word to serialize
//                bit_o   - serial bit (registered)
//                valid_o - bit_o is valid (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_piso
   import scan_frame_pkg::*;
#(
   parameter int WIDTH = c_def_width
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             bit_o,
   output logic             valid_o
);

   localparam int                 c_cnt_w = cnt_width(WIDTH);
   localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(WIDTH);

   logic [WIDTH-1:0]   sr_q, sr_d;
   logic [c_cnt_w-1:0] cnt_q, cnt_d;
   logic               valid_q, valid_d;

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (load_i) begin
         sr_d  = data_i;
         cnt_d = c_full;
      end else if (cnt_q != '0) begin
         // Zeros shift in, so bit_o rests at 0 once the burst is over.
         sr_d  = sr_q >> 1;
         cnt_d = cnt_q - c_cnt_w'(1);
      end
      // Valid is registered alongside the shifter so it tracks cnt_q != 0.
      valid_d = (cnt_d != '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q    <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign bit_o   = sr_q[0];
   assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/scan_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : scan_frame_loader
//  Description : Serial-to-parallel stimulus loader and result capturer for
//                an 8-in/8-out user slot. Shifts a WIDTH-bit frame in LSB
//                first, applies it to user_in, waits SETTLE cycles, captures
//                user_out and streams it back LSB first.
//  Ports       : clk          - clock
//                reset        - asynchronous active-high reset
//                sd_in        - serial stimulus bit
//                sd_valid     - sd_in valid
//                sd_ready     - loader accepts a bit (decoded from FSM)
//                user_in      - stimulus word to the user slot (registered)
//                user_out     - response word from the user slot
//                sd_out       - serial result bit (registered)
//                sd_out_valid - sd_out valid (registered)
//                frame_done   - one-cycle pulse after capture (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_frame_loader
   import scan_frame_pkg::*;
#(
   parameter int WIDTH  = c_def_width,   // must be >= 2
   parameter int SETTLE = c_def_settle   // 1..15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sd_in,
   input  logic             sd_valid,
   output logic             sd_ready,
   output logic [WIDTH-1:0] user_in,
   input  logic [WIDTH-1:0] user_out,
   output logic             sd_out,
   output logic             sd_out_valid,
   output logic             frame_done
);

   localparam int                        c_bit_cnt_w   = cnt_width(WIDTH);
   localparam logic [c_bit_cnt_w-1:0]    c_last_bit    = c_bit_cnt_w'(WIDTH - 1);
   localparam logic [c_settle_cnt_w-1:0] c_settle_init = c_settle_cnt_w'(SETTLE - 1);

   state_e                    state_q, state_d;
   logic [WIDTH-1:0]          in_sr_q, in_sr_d;
   logic [WIDTH-1:0]          user_in_q, user_in_d;
   logic [c_bit_cnt_w-1:0]    bit_cnt_q, bit_cnt_d;
   logic [c_settle_cnt_w-1:0] settle_cnt_q, settle_cnt_d;
   logic                      frame_done_q, frame_done_d;
   logic                      capture;

   always_comb begin
      state_d      = state_q;
      in_sr_d      = in_sr_q;
      user_in_d    = user_in_q;
      bit_cnt_d    = bit_cnt_q;
      settle_cnt_d = settle_cnt_q;
      frame_done_d = 1'b0;
      capture      = 1'b0;
      sd_ready     = 1'b0;

      case (state_q)
         ST_IDLE, ST_SHIFT: begin
            sd_ready = 1'b1;
            if (sd_valid) begin
               // Enter at the MSB so the first bit ends up in bit 0.
               in_sr_d = {sd_in, in_sr_q[WIDTH-1:1]};
               if (bit_cnt_q == c_last_bit) begin
                  bit_cnt_d = '0;
                  state_d   = ST_APPLY;
               end else begin
                  bit_cnt_d = bit_cnt_q + c_bit_cnt_w'(1);
                  state_d   = ST_SHIFT;
               end
            end
         end

         ST_APPLY: begin
            user_in_d    = in_sr_q;
            settle_cnt_d = c_settle_init;
            state_d      = ST_SETTLE;
         end

         ST_SETTLE: begin
            if (settle_cnt_q == '0) begin
               capture      = 1'b1;
               frame_done_d = 1'b1;
               state_d      = ST_IDLE;
            end else begin
               settle_cnt_d = settle_cnt_q - c_settle_cnt_w'(1);
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         in_sr_q      <= '0;
         user_in_q    <= '0;
         bit_cnt_q    <= '0;
         settle_cnt_q <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_sr_q      <= in_sr_d;
         user_in_q    <= user_in_d;
         bit_cnt_q    <= bit_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign user_in    = user_in_q;
   assign frame_done = frame_done_q;

   // Capture happens on the same edge that loads the output shifter.
   scan_piso #(
      .WIDTH (WIDTH)
   ) u_piso (
      .clk     (clk),
      .reset   (reset),
      .load_i  (capture),
      .data_i  (user_out),
      .bit_o   (sd_out),
      .valid_o (sd_out_valid)
   );

endmodule
`default_nettype wire

// File: tb/tb_scan_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_frame_loader
//  Description : Scoreboard bench for scan_frame_loader. Two instances: the
//                default build (slot model user_out = user_in ^ 0x99) and a
//                SETTLE=3 build whose slot output encodes cycles since
//                user_in changed (0xC0 | age).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_frame_loader;

   logic       clk;
   logic       reset;

   logic       sd_in, sd_valid, sd_ready, sd_out, sd_out_valid, frame_done;
   logic [7:0] user_in, user_out;

   logic       sd_in3, sd_valid3, sd_ready3, sd_out3, sd_out_valid3, frame_done3;
   logic [7:0] user_in3, user_out3;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] ui_q[$];
   logic       bit_q[$];
   logic [7:0] ui3_q[$];
   logic       bit3_q[$];

   scan_frame_loader #(.WIDTH(8), .SETTLE(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .sd_in        (sd_in),
      .sd_valid     (sd_valid),
      .sd_ready     (sd_ready),
      .user_in      (user_in),
      .user_out     (user_out),
      .sd_out       (sd_out),
      .sd_out_valid (sd_out_valid),
      .frame_done   (frame_done)
   );

   scan_frame_loader #(.WIDTH(8), .SETTLE(3)) dut3 (
      .clk          (clk),
      .reset        (reset),
      .sd_in        (sd_in3),
      .sd_valid     (sd_valid3),
      .sd_ready     (sd_ready3),
      .user_in      (user_in3),
      .user_out     (user_out3),
      .sd_out       (sd_out3),
      .sd_out_valid (sd_out_valid3),
      .frame_done   (frame_done3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Default slot: combinational XOR.
   assign user_out = user_in ^ 8'h99;

   // SETTLE=3 slot: output reveals how many cycles user_in3 has been stable.
   logic [7:0] last_ui3;
   logic [3:0] age3 = 4'd0;
   always @(negedge clk) begin
      if (user_in3 !== last_ui3) begin
         age3     = 4'd0;
         last_ui3 = user_in3;
      end else if (age3 != 4'd15) begin
         age3 = age3 + 4'd1;
      end
      user_out3 = {4'hC, age3};
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitors: pop expected values whenever the DUTs present output.
   always @(negedge clk) begin
      logic [7:0] eu;
      logic       eb;
      if (frame_done) begin
         if (ui_q.size() == 0) chk("spurious_frame_done", frame_done, 1'b0);
         else begin eu = ui_q.pop_front(); chk("user_in_at_done", user_in, eu); end
      end
      if (sd_out_valid) begin
         if (bit_q.size() == 0) chk("spurious_sd_out_valid", sd_out_valid, 1'b0);
         else begin eb = bit_q.pop_front(); chk("sd_out_bit", sd_out, eb); end
      end
      if (frame_done3) begin
         if (ui3_q.size() == 0) chk("spurious_frame_done3", frame_done3, 1'b0);
         else begin eu = ui3_q.pop_front(); chk("user_in3_at_done", user_in3, eu); end
      end
      if (sd_out_valid3) begin
         if (bit3_q.size() == 0) chk("spurious_sd_out_valid3", sd_out_valid3, 1'b0);
         else begin eb = bit3_q.pop_front(); chk("sd_out3_bit", sd_out3, eb); end
      end
   end

   function automatic logic rdy(input bit sel);
      return sel ? sd_ready3 : sd_ready;
   endfunction

   function automatic logic done(input bit sel);
      return sel ? frame_done3 : frame_done;
   endfunction

   function automatic logic [7:0] ui(input bit sel);
      return sel ? user_in3 : user_in;
   endfunction

   task automatic drive(input bit sel, input logic v, input logic d);
      if (sel) begin sd_valid3 = v; sd_in3 = d; end
      else     begin sd_valid  = v; sd_in  = d; end
   endtask

   // Offer one bit, holding it until the loader is ready (bounded).
   task automatic put_bit(input bit sel, input logic b);
      int n;
      n = 0;
      drive(sel, 1'b1, b);
      while (!rdy(sel) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) chk("sd_ready_timeout", rdy(sel), 1'b1);
      @(posedge clk); #1;
      drive(sel, 1'b0, ~b);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] v, input logic [7:0] res,
                             input bit gaps, input bit timing, input int settle,
                             input bit check_hold, input logic [7:0] hold_val);
      if (sel) begin
         ui3_q.push_back(v);
         for (int i = 0; i < 8; i++) bit3_q.push_back(res[i]);
      end else begin
         ui_q.push_back(v);
         for (int i = 0; i < 8; i++) bit_q.push_back(res[i]);
      end
      for (int i = 0; i < 8; i++) begin
         if (gaps && i > 0) begin
            repeat ($urandom_range(0, 2)) begin
               drive(sel, 1'b0, ~v[i]);
               @(posedge clk); #1;
            end
         end
         if (check_hold && i == 7) chk("user_in_hold", ui(sel), hold_val);
         put_bit(sel, v[i]);
      end
      if (timing) begin
         for (int k = 0; k <= settle + 1; k++) begin
            chk("sd_ready_window", rdy(sel), (k <= settle) ? 1'b0 : 1'b1);
            chk("frame_done_timing", done(sel), (k == settle + 1) ? 1'b1 : 1'b0);
            if (k >= 1) chk("user_in_applied", ui(sel), v);
            if (k <= settle) begin @(posedge clk); #1; end
         end
      end
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_user_in"},      user_in,      8'h00);
      chk({tag, "_sd_ready"},     sd_ready,     1'b1);
      chk({tag, "_sd_out"},       sd_out,       1'b0);
      chk({tag, "_sd_out_valid"}, sd_out_valid, 1'b0);
      chk({tag, "_frame_done"},   frame_done,   1'b0);
   endtask

   initial begin
      int n;
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("por");
      chk("por_sd_ready3", sd_ready3, 1'b1);
      chk("por_user_in3", user_in3, 8'h00);
      reset = 1'b0;
      @(posedge clk); #1;

      // 0xA5 back-to-back bits, slot returns 0x3C -> serial 0,0,1,1,1,1,0,0.
      send_frame(1'b0, 8'hA5, 8'h3C, 1'b0, 1'b1, 1, 1'b0, 8'h00);
      repeat (12) begin @(posedge clk); #1; end

      // 0x24, then 0x81 with gaps; first 0x81 bit is offered while not ready.
      send_frame(1'b0, 8'h24, 8'hBD, 1'b0, 1'b0, 1, 1'b0, 8'h00);
      send_frame(1'b0, 8'h81, 8'h18, 1'b1, 1'b1, 1, 1'b1, 8'h24);
      repeat (12) begin @(posedge clk); #1; end

      // Back-to-back frames; second input overlaps first output burst.
      send_frame(1'b0, 8'h12, 8'h8B, 1'b0, 1'b0, 1, 1'b0, 8'h00);
      send_frame(1'b0, 8'hFE, 8'h67, 1'b0, 1'b1, 1, 1'b1, 8'h12);
      repeat (12) begin @(posedge clk); #1; end

      // SETTLE=3: capture must see age 2 -> 0xC2.
      send_frame(1'b1, 8'h5A, 8'hC2, 1'b0, 1'b1, 3, 1'b0, 8'h00);
      repeat (12) begin @(posedge clk); #1; end

      // Reset after 5 bits of 0xFF.
      for (int i = 0; i < 5; i++) put_bit(1'b0, 1'b1);
      reset = 1'b1;
      #1;
      check_reset_state("rst_shift");
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      send_frame(1'b0, 8'h0F, 8'h96, 1'b0, 1'b1, 1, 1'b0, 8'h00);

      // Reset in the middle of the 0x96 output burst.
      n = 0;
      while (!sd_out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) chk("sd_out_valid_timeout", sd_out_valid, 1'b1);
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b1;
      bit_q.delete();
      ui_q.delete();
      #1;
      check_reset_state("rst_output");
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      send_frame(1'b0, 8'h33, 8'hAA, 1'b1, 1'b1, 1, 1'b0, 8'h00);
      repeat (20) begin @(posedge clk); #1; end

      chk("leftover_user_in",  ui_q.size(),   0);
      chk("leftover_bits",     bit_q.size(),  0);
      chk("leftover_user_in3", ui3_q.size(),  0);
      chk("leftover_bits3",    bit3_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
